// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; 33-cycle accept-to-valid.
// RV32M_DIV_EARLY_OUT_EN: divide-by-zero/overflow finish in 1 cycle. No queueing: start ignored while busy.
module rv32m_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_d;
  logic            busy_d, valid_d, load_res;
  logic [XLEN-1:0] res_d;

  logic [XLEN-1:0] quo_q, rem_q, dvsr_q, spec_val_q;
  logic [4:0]      cnt_q;
  logic            sel_rem_q, q_neg_q, r_neg_q, special_q;

  // Accept-time operand conditioning
  logic            accept, is_signed, a_neg, b_neg, div_zero, ovf, special_in;
  logic [XLEN-1:0] a_mag, b_mag, spec_val_in;

  always_comb begin
    accept      = (state == IDLE) && start && !flush;
    is_signed   = ~op[0];
    a_neg       = is_signed & dividend[XLEN-1];
    b_neg       = is_signed & divisor[XLEN-1];
    a_mag       = a_neg ? -dividend : dividend;
    b_mag       = b_neg ? -divisor : divisor;
    div_zero    = (divisor == '0);
    ovf         = is_signed && (dividend == INT_MIN) && (divisor == '1);
    special_in  = div_zero | ovf;
    // Divide-by-zero wins over overflow
    if (div_zero)
      spec_val_in = op[1] ? dividend : '1;
    else
      spec_val_in = op[1] ? '0 : INT_MIN;
  end

  // One restoring step; the final step feeds the result register directly
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] rem_nx, quo_nx, raw, signed_res, fin;
  logic            neg;

  always_comb begin
    rem_sh     = {rem_q, quo_q[XLEN-1]};
    diff       = rem_sh - {1'b0, dvsr_q};
    rem_nx     = diff[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : diff[XLEN-1:0];
    quo_nx     = {quo_q[XLEN-2:0], ~diff[XLEN]};
    raw        = sel_rem_q ? rem_nx : quo_nx;
    neg        = sel_rem_q ? r_neg_q : q_neg_q;
    signed_res = neg ? -raw : raw;
    fin        = special_q ? spec_val_q : signed_res;
  end

  always_comb begin
    state_d  = state;
    busy_d   = busy;
    valid_d  = 1'b0;
    load_res = 1'b0;
    res_d    = fin;
    case (state)
      IDLE: begin
        if (accept) begin
          busy_d  = 1'b1;
          state_d = CALC;
`ifdef RV32M_DIV_EARLY_OUT_EN
          if (special_in) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            load_res = 1'b1;
            res_d    = spec_val_in;
          end
`endif
        end
      end
      CALC: begin
        if (cnt_q == 5'd0) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          load_res = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (flush) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      load_res = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      result     <= '0;
      cnt_q      <= 5'd0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      spec_val_q <= '0;
      sel_rem_q  <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      special_q  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      valid <= valid_d;
      if (load_res)
        result <= res_d;
      if (accept) begin
        quo_q      <= a_mag;
        rem_q      <= '0;
        dvsr_q     <= b_mag;
        cnt_q      <= 5'd31;
        sel_rem_q  <= op[1];
        q_neg_q    <= a_neg ^ b_neg;
        r_neg_q    <= a_neg;
        special_q  <= special_in;
        spec_val_q <= spec_val_in;
      end else if (state == CALC) begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
        cnt_q <= cnt_q - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Self-checking bench for rv32m_div_unit: directed RV32M cases plus randomized ops vs an arithmetic model.
module tb_rv32m_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcount = 0;
  int vcyc = 0;
  int dbl_valid = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] vres = '0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  rv32m_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      vcyc = cyc;
      vres = result;
      if (prev_valid) dbl_valid++;
    end
    prev_valid = valid;
  end

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] t;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    if (o[0]) return o[1] ? (a % b) : (a / b);
    sa = $signed(a);
    sb = $signed(b);
    t = o[1] ? (sa % sb) : (sa / sb);
    return t[31:0];
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic special;
    special = (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef RV32M_DIV_EARLY_OUT_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction

  // Drives one op, returns observed result, accept-to-valid latency and busy/valid protocol violations.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int proto_bad);
    @(posedge clk); #1;
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom);
    lat = -1; proto_bad = 0; res = 32'hDEAD_BEEF;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k;
        res = result;
        if (!busy) proto_bad++;
        break;
      end
      if (!busy) proto_bad++;
    end
    @(negedge clk);
    if (busy || valid) proto_bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [10] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV};
    logic [31:0] as  [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat, bad, elat;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bad);
      elat = model_lat(ops[i], as[i], bs[i]);
      checks++; if (res !== exp[i]) begin failures++; $display("FAIL directed%0d_result got=%h exp=%h", i, res, exp[i]); end
      checks++; if (lat != elat) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, elat); end
      checks++; if (bad != 0) begin failures++; $display("FAIL directed%0d_busy_protocol got=%0d exp=0", i, bad); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, res, exp;
    int lat, bad, elat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      exp = model(o, a, b);
      elat = model_lat(o, a, b);
      run_op(o, a, b, res, lat, bad);
      checks++; if (res !== exp || lat != elat || bad != 0) begin
        failures++;
        $display("FAIL random%0d op=%0d a=%h b=%h got=%h/lat%0d/bad%0d exp=%h/lat%0d/bad0",
                 i, o, a, b, res, lat, bad, exp, elat);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n, v0;
    @(posedge clk); #1;
    v0 = vcount; n = cyc;
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++; if (vcount - v0 != 1) begin failures++; $display("FAIL busy_start_valid_count got=%0d exp=1", vcount - v0); end
    checks++; if (vcyc != n + 33) begin failures++; $display("FAIL busy_start_valid_cycle got=%0d exp=%0d", vcyc - n, 33); end
    checks++; if (vres !== 32'd14) begin failures++; $display("FAIL busy_start_result got=%h exp=%h", vres, 32'd14); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
  endtask

  task automatic test_flush();
    int n, v0;
    @(posedge clk); #1;
    v0 = vcount; n = cyc;
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (11) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++; if (vcount - v0 != 1) begin failures++; $display("FAIL flush_valid_count got=%0d exp=1", vcount - v0); end
    checks++; if (vcyc != n + 47) begin failures++; $display("FAIL flush_valid_cycle got=%0d exp=47", vcyc - n); end
    checks++; if (vres !== 32'd3) begin failures++; $display("FAIL flush_result got=%h exp=%h", vres, 32'd3); end
  endtask

  task automatic test_reset_mid_calc();
    int v0;
    @(posedge clk); #1;
    v0 = vcount;
    start = 1'b1; op = OP_DIVU; dividend = 32'd77; divisor = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL midrst_result got=%h exp=0", result); end
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++; if (vcount != v0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", vcount - v0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_flush();
    test_random();
    test_reset_mid_calc();
    checks++; if (dbl_valid != 0) begin failures++; $display("FAIL valid_single_pulse got=%0d exp=0", dbl_valid); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
